serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port x, input, WIDTH bits: minuend.
REQ-006 The block SHALL have port y, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port b_in, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: result, x - y - b_in mod 2^WIDTH.
REQ-011 The block SHALL have port b_out, output, 1 bit: borrow-out, set when x < y + b_in (unsigned).

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY and DONE; transitions are IDLE->BUSY on start, BUSY->DONE after WIDTH bit steps, and DONE->IDLE, or DONE->BUSY when start is high.
REQ-013 The block SHALL latch x, y and b_in, clear the bit counter, set busy=1 and enter BUSY at edge N when start=1 is sampled in IDLE or DONE.
REQ-014 In BUSY, the block SHALL process one bit per edge, LSB first: d_i = x_i ^ y_i ^ b and b' = (~x_i & y_i) | (~(x_i ^ y_i) & b), with b seeded from the latched b_in.
REQ-015 At edge N+WIDTH, the block SHALL write diff and b_out, set done=1 and busy=0, and enter DONE, giving a latency of WIDTH cycles from the start edge to done.
REQ-016 done SHALL be high for exactly one cycle per accepted operation.
REQ-017 diff and b_out SHALL hold their values until the next done edge.
REQ-018 The block SHALL ignore start while in BUSY: no restart, and the latched operands are unchanged.
REQ-019 Input changes on x, y and b_in after the accepting edge SHALL NOT affect the result.
REQ-020 Back-to-back operation: start=1 during the DONE cycle SHALL be accepted, giving a throughput of one result per WIDTH+1 cycles.
REQ-021 Boundaries: x=y with b_in=0 SHALL give diff=0, b_out=0; x=0, y=0, b_in=1 SHALL give diff all-ones, b_out=1.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE and set busy=0, done=0, diff=0, b_out=0, clear the counter and clear the internal borrow.
REQ-023 rst SHALL take priority over start at the same edge.
REQ-024 Reset during BUSY SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL run normally.

Configuration
REQ-025 The macro SUB_OVERFLOW_EN SHALL control a signed-overflow output.
REQ-026 When SUB_OVERFLOW_EN is defined, the block SHALL add output port ovf, 1 bit, equal to (x_msb ^ y_msb) & (x_msb ^ diff_msb) of the completed operation; ovf shall update with diff and reset to 0.
REQ-027 When SUB_OVERFLOW_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 The bench SHALL cover: WIDTH=32, x=0x4C9F60A3, y=0x05C1780C, b_in=0, start pulse -> done exactly 32 cycles later, diff=0x46DDE897, b_out=0.
REQ-029 The bench SHALL cover: x=0, y=1, b_in=0 -> diff=0xFFFFFFFF, b_out=1; x=0, y=0, b_in=1 -> diff=0xFFFFFFFF, b_out=1.
REQ-030 The bench SHALL cover: SUB_OVERFLOW_EN defined, x=0x80000000, y=0x00000001 -> diff=0x7FFFFFFF, ovf=1, b_out=0.
REQ-031 The bench SHALL cover: start with x=7, y=2; at cycle 10 drive start with x=100, y=1 -> ignored, result diff=5, a single done pulse.
REQ-032 The bench SHALL cover: rst asserted at cycle 10 of BUSY -> busy=0, diff=0, no done; next start with x=9, y=4 -> diff=5 after 32 cycles.
REQ-033 The bench SHALL cover: start held high continuously with x=10, y=3 -> done every 33 cycles, diff=7 each time.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: x - y - b_in, LSB first, one bit per clock; result and borrow after WIDTH cycles.
// Optional signed-overflow output ovf when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;

  logic d_bit_d;
  logic borrow_d;
  logic last_d;

  assign d_bit_d  = x_q[0] ^ y_q[0] ^ borrow_q;
  assign borrow_d = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & borrow_q);
  assign last_d   = (cnt_q == CW'(WIDTH - 1));

  // x_q doubles as the result accumulator: difference bits enter at the top as operand bits leave the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            x_q      <= x;
            y_q      <= y;
            borrow_q <= b_in;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= BUSY;
          end else begin
            state_q  <= IDLE;
          end
        end
        BUSY: begin
          x_q      <= {d_bit_d, x_q[WIDTH-1:1]};
          y_q      <= y_q >> 1;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_d) begin
            // On the last step x_q[0]/y_q[0] are the operand sign bits and d_bit_d is the result sign bit.
            diff    <= {d_bit_d, x_q[WIDTH-1:1]};
            b_out   <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            ovf     <= (x_q[0] ^ y_q[0]) & (x_q[0] ^ d_bit_d);
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=32) using an expected-result queue.
module tb_serial_subtractor;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] diff;
    logic         b;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         b_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] s, input logic bi);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, s} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.b    = r[W];
    e.ovf  = (a[W-1] ^ s[W-1]) & (a[W-1] ^ r[W-1]);
    return e;
  endfunction

  // One-cycle start pulse; expected result queued at acceptance, then inputs scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] s, input logic bi);
    x = a; y = s; b_in = bi; start = 1'b1;
    exp_q.push_back(model(a, s, bi));
    tick();
    start = 1'b0;
    x = $urandom; y = $urandom; b_in = 1'($urandom_range(0, 1));
  endtask

  task automatic await_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; start = 1'b1; x = 32'd50; y = 32'd1;
    tick(); tick();
    start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff got %h want 0", diff); end
    n_tests++; if (b_out !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b want 0", b_out); end
`ifdef SUB_OVERFLOW_EN
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy got %b want 0", busy); end
    e = model('0, '0, 1'b0);
  endtask

  task automatic test_basic();
    int lat;
    exp_t e;
    issue(32'h4C9F60A3, 32'h05C1780C, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    await_done(lat);
    e = exp_q.pop_front();
    n_tests++; if (lat !== W) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL basic_diff got %h want %h", diff, e.diff); end
    n_tests++; if (b_out !== e.b) begin n_fail++; $display("FAIL basic_bout got %b want %b", b_out, e.b); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", done); end
    repeat (3) tick();
    n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL basic_diff_hold got %h want %h", diff, e.diff); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] xs [5] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h80000000, 32'h7FFFFFFF};
    logic [W-1:0] ys [5] = '{32'h1, 32'h0, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};
    logic         bs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(xs[i], ys[i], bs[i]);
      await_done(lat);
      e = exp_q.pop_front();
      n_tests++; if (lat !== W) begin n_fail++; $display("FAIL bound%0d_latency got %0d want %0d", i, lat, W); end
      n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL bound%0d_diff got %h want %h", i, diff, e.diff); end
      n_tests++; if (b_out !== e.b) begin n_fail++; $display("FAIL bound%0d_bout got %b want %b", i, b_out, e.b); end
`ifdef SUB_OVERFLOW_EN
      n_tests++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL bound%0d_ovf got %b want %b", i, ovf, e.ovf); end
`endif
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int d0;
    exp_t e;
    d0 = done_cnt;
    issue(32'd7, 32'd2, 1'b0);
    repeat (9) tick();
    x = 32'd100; y = 32'd1; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    await_done(lat);
    e = exp_q.pop_front();
    n_tests++; if (lat + 10 !== W) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat + 10, W); end
    n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL ignore_diff got %h want %h", diff, e.diff); end
    repeat (40) tick();
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignore_pulses got %0d want 1", done_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_busy();
    int lat;
    int d0;
    exp_t e;
    issue(32'hFFFF0000, 32'h1, 1'b0);
    repeat (9) tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_front());
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstbusy_busy got %b want 0", busy); end
    n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL rstbusy_diff got %h want 0", diff); end
    repeat (40) tick();
    n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstbusy_nodone got %0d want %0d", done_cnt - d0, 0); end
    issue(32'd9, 32'd4, 1'b0);
    await_done(lat);
    e = exp_q.pop_front();
    n_tests++; if (lat !== W) begin n_fail++; $display("FAIL rstbusy_latency got %0d want %0d", lat, W); end
    n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL rstbusy_diff2 got %h want %h", diff, e.diff); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    x = 32'd10; y = 32'd3; b_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(model(32'd10, 32'd3, 1'b0));
    tick();
    for (int i = 0; i < 4; i++) begin
      await_done(lat);
      if (i == 3) start = 1'b0;
      e = exp_q.pop_front();
      n_tests++; if (lat !== ((i == 0) ? W : W + 1)) begin n_fail++; $display("FAIL b2b%0d_interval got %0d want %0d", i, lat, (i == 0) ? W : W + 1); end
      n_tests++; if (diff !== e.diff) begin n_fail++; $display("FAIL b2b%0d_diff got %h want %h", i, diff, e.diff); end
    end
    start = 1'b0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_start_ignored();
    test_reset_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
